bit_population_generator: RTL and testbench

- Stream source that produces the other direction of our population counter: it accepts a requested ones-count and emits a WIDTH-bit word containing exactly that many set bits.
- Bit positions are chosen pseudo-randomly by an internal free-running LFSR.
- Used as a stimulus/pattern source that feeds bit_population_counter and other popcount consumers.
- Both sides use valid/ready handshakes; one word is in flight at a time.

---
 rtl/bit_population_generator.sv | 182 ++++++++++++++++++
 tb/tb_bit_population_generator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_population_generator.sv
// Pattern source: takes a requested ones-count and produces a WIDTH-bit word
// with exactly that many set bits. A free-running 16-bit Galois LFSR picks
// the bit positions.
//
// Parameters:
//   WIDTH : output word width (power of two, >= 4)
//   SEED  : 16-bit LFSR reset value (0 is replaced by 16'h0001)
//
// Ports:
//   clk_i      : clock
//   srst_i     : synchronous reset, active-high
//   cnt_i      : requested number of set bits (saturates at WIDTH)
//   cnt_val_i  : cnt_i valid
//   cnt_rdy_o  : generator can accept a request (registered)
//   data_o     : generated word (registered, held after handshake)
//   data_val_o : data_o valid (registered)
//   data_rdy_i : downstream accepts data_o
//
// Optional build macro:
//   BIT_POP_GEN_COMPLEMENT_EN : counts above WIDTH/2 start from all ones and
//   clear WIDTH-Nc bits instead, bounding latency to WIDTH/2+1.
module bit_population_generator #(
  parameter int unsigned WIDTH = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [$clog2(WIDTH):0]   cnt_i,
  input  logic                     cnt_val_i,
  output logic                     cnt_rdy_o,
  output logic [WIDTH-1:0]         data_o,
  output logic                     data_val_o,
  input  logic                     data_rdy_i
);

  localparam int unsigned IDX_W     = $clog2(WIDTH);
  localparam int unsigned CNT_W     = IDX_W + 1;
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_OUT
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               cnt_rdy_q, cnt_rdy_d;
  logic               data_val_q, data_val_d;
`ifdef BIT_POP_GEN_COMPLEMENT_EN
  logic               clear_mode_q, clear_mode_d;
`endif

  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   nc;
  logic [WIDTH-1:0]   target_vec;
  logic [IDX_W-1:0]   pick;

  // First set bit of vec at or above start, wrapping past the top bit:
  // rotate so start lands at bit 0, then priority-encode the lowest one.
  function automatic logic [IDX_W-1:0] first_set_from(
    input logic [WIDTH-1:0] vec,
    input logic [IDX_W-1:0] start
  );
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   rot;
    logic [IDX_W-1:0]   enc;
    dbl = {vec, vec} >> start;
    rot = dbl[WIDTH-1:0];
    enc = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
    first_set_from = start + enc;
  endfunction

  assign cnt_rdy_o  = cnt_rdy_q;
  assign data_o     = data_q;
  assign data_val_o = data_val_q;

  assign idx    = lfsr_q[IDX_W-1:0];
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  assign nc     = (cnt_i > CNT_MAX) ? CNT_MAX : cnt_i;

  // Candidate bits: clear bits when setting, set bits when clearing.
`ifdef BIT_POP_GEN_COMPLEMENT_EN
  assign target_vec = clear_mode_q ? mask_q : ~mask_q;
`else
  assign target_vec = ~mask_q;
`endif
  assign pick = first_set_from(target_vec, idx);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    cnt_rdy_d   = cnt_rdy_q;
    data_val_d  = data_val_q;
`ifdef BIT_POP_GEN_COMPLEMENT_EN
    clear_mode_d = clear_mode_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cnt_val_i && cnt_rdy_q) begin
          state_d     = ST_GEN;
          cnt_rdy_d   = 1'b0;
          mask_d      = '0;
          remaining_d = nc;
`ifdef BIT_POP_GEN_COMPLEMENT_EN
          clear_mode_d = 1'b0;
          if (nc > CNT_W'(WIDTH / 2)) begin
            mask_d       = '1;
            remaining_d  = CNT_MAX - nc;
            clear_mode_d = 1'b1;
          end
`endif
        end
      end
      ST_GEN: begin
        if (remaining_q != '0) begin
`ifdef BIT_POP_GEN_COMPLEMENT_EN
          mask_d[pick] = ~clear_mode_q;
`else
          mask_d[pick] = 1'b1;
`endif
          remaining_d = remaining_q - CNT_W'(1);
        end else begin
          data_d     = mask_q;
          data_val_d = 1'b1;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (data_rdy_i) begin
          state_d    = ST_IDLE;
          data_val_d = 1'b0;
          cnt_rdy_d  = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_rdy_d  = 1'b1;
        data_val_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= SEED_EFF;
      mask_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      cnt_rdy_q   <= 1'b1;
      data_val_q  <= 1'b0;
`ifdef BIT_POP_GEN_COMPLEMENT_EN
      clear_mode_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      mask_q      <= mask_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      cnt_rdy_q   <= cnt_rdy_d;
      data_val_q  <= data_val_d;
`ifdef BIT_POP_GEN_COMPLEMENT_EN
      clear_mode_q <= clear_mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_population_generator.sv
// Directed bench for bit_population_generator (WIDTH=16). A reference LFSR
// and bit-pick model predicts the exact word for every request.
module tb_bit_population_generator;

  localparam int unsigned WIDTH = 16;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b1;
  logic [4:0]  cnt_i = '0;
  logic        cnt_val_i = 1'b0;
  logic        cnt_rdy_o;
  logic [15:0] data_o;
  logic        data_val_o;
  logic        data_rdy_i = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;

  always #5 clk_i = ~clk_i;

  bit_population_generator #(.WIDTH(WIDTH), .SEED(SEED)) dut (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .cnt_i      (cnt_i),
    .cnt_val_i  (cnt_val_i),
    .cnt_rdy_o  (cnt_rdy_o),
    .data_o     (data_o),
    .data_val_o (data_val_o),
    .data_rdy_i (data_rdy_i)
  );

  // Reference Galois LFSR, x^16+x^14+x^13+x^11+1
  always @(posedge clk_i) begin
    if (srst_i) m_lfsr <= SEED;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Flip the first bit equal to clr, scanning upward from idx with wrap.
  function automatic logic [15:0] model_step(input logic [15:0] mask,
                                             input logic [3:0] idx, input bit clr);
    logic [15:0] r;
    logic [3:0]  p;
    r = mask;
    for (int k = 0; k < 16; k++) begin
      p = idx + 4'(k);
      if (r[p] == clr) begin
        r[p] = ~clr;
        return r;
      end
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [4:0] cnt);
    int nc;
    nc = (cnt > 5'd16) ? 16 : int'(cnt);
`ifdef BIT_POP_GEN_COMPLEMENT_EN
    if (nc > 8) return 16 - nc + 1;
`endif
    return nc + 1;
  endfunction

  task automatic do_reset();
    srst_i = 1'b1;
    @(posedge clk_i); #1;
    srst_i = 1'b0;
  endtask

  // Issue one request from IDLE and wait (bounded) for data_val_o.
  task automatic run_req(input logic [4:0] cnt, output logic [15:0] exp_w,
                         output int lat, output logic [15:0] got_w, output bit to);
    int nc, rem;
    bit clr;
    logic [15:0] m;
    nc  = (cnt > 5'd16) ? 16 : int'(cnt);
    clr = 1'b0;
    m   = 16'h0000;
    rem = nc;
`ifdef BIT_POP_GEN_COMPLEMENT_EN
    if (nc > 8) begin
      clr = 1'b1;
      m   = 16'hFFFF;
      rem = 16 - nc;
    end
`endif
    cnt_i = cnt;
    cnt_val_i = 1'b1;
    @(posedge clk_i); #1;
    cnt_val_i = 1'b0;
    lat = 0;
    to  = 1'b0;
    while (data_val_o !== 1'b1 && !to) begin
      if (rem > 0) begin
        m = model_step(m, m_lfsr[3:0], clr);
        rem--;
      end
      @(posedge clk_i); #1;
      lat++;
      if (lat > 40) to = 1'b1;
    end
    exp_w = m;
    got_w = data_o;
  endtask

  task automatic test_reset();
    cnt_val_i = 1'b0;
    data_rdy_i = 1'b1;
    srst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    srst_i = 1'b0;
    n_checks++; if (cnt_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_cnt_rdy: got %b want 1", cnt_rdy_o); end
    n_checks++; if (data_val_o !== 1'b0) begin n_fail++; $display("FAIL reset_data_val: got %b want 0", data_val_o); end
    n_checks++; if (data_o !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data_o); end
  endtask

  task automatic test_zero();
    logic [15:0] e, g; int lat; bit to;
    run_req(5'd0, e, lat, g, to);
    n_checks++; if (to || lat != 1) begin n_fail++; $display("FAIL zero_latency: got %0d want 1 (timeout %0b)", lat, to); end
    n_checks++; if (g !== 16'h0000) begin n_fail++; $display("FAIL zero_data: got %h want 0000", g); end
    n_checks++; if (cnt_rdy_o !== 1'b0) begin n_fail++; $display("FAIL zero_rdy_in_out: got %b want 0", cnt_rdy_o); end
    @(posedge clk_i); #1;
    n_checks++; if (data_val_o !== 1'b0) begin n_fail++; $display("FAIL zero_val_drop: got %b want 0", data_val_o); end
    n_checks++; if (cnt_rdy_o !== 1'b1) begin n_fail++; $display("FAIL zero_rdy_back: got %b want 1", cnt_rdy_o); end
  endtask

  task automatic test_five();
    logic [15:0] e, g; int lat; bit to;
    run_req(5'd5, e, lat, g, to);
    n_checks++; if (to || lat != 6) begin n_fail++; $display("FAIL five_latency: got %0d want 6", lat); end
    n_checks++; if ($countones(g) != 5) begin n_fail++; $display("FAIL five_popcount: got %0d want 5", $countones(g)); end
    n_checks++; if (g !== e) begin n_fail++; $display("FAIL five_word: got %h want %h", g, e); end
    @(posedge clk_i); #1;
    n_checks++; if (data_o !== e) begin n_fail++; $display("FAIL five_hold: got %h want %h", data_o, e); end
  endtask

  task automatic test_full();
    logic [4:0] cnts [4] = '{5'd16, 5'd20, 5'd13, 5'd9};
    logic [15:0] e, g; int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      run_req(cnts[i], e, lat, g, to);
      n_checks++; if (to || lat != exp_lat(cnts[i])) begin n_fail++; $display("FAIL full_latency cnt=%0d: got %0d want %0d", cnts[i], lat, exp_lat(cnts[i])); end
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL full_word cnt=%0d: got %h want %h", cnts[i], g, e); end
      if (i < 2) begin
        n_checks++; if (g !== 16'hFFFF) begin n_fail++; $display("FAIL full_ones cnt=%0d: got %h want ffff", cnts[i], g); end
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_random();
    logic [15:0] e, g; int lat; bit to; logic [4:0] c;
    for (int i = 0; i < 1000; i++) begin
      c = 5'($urandom_range(0, 16));
      run_req(c, e, lat, g, to);
      n_checks++; if (to || $countones(g) != int'(c)) begin n_fail++; $display("FAIL rand_popcount cnt=%0d: got %0d", c, $countones(g)); end
      n_checks++; if (g !== e || lat != exp_lat(c)) begin n_fail++; $display("FAIL rand_word cnt=%0d: got %h/lat %0d want %h/lat %0d", c, g, lat, e, exp_lat(c)); end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e, g; int lat; bit to;
    data_rdy_i = 1'b0;
    run_req(5'd7, e, lat, g, to);
    n_checks++; if (to || g !== e || $countones(g) != 7) begin n_fail++; $display("FAIL bp_word: got %h want %h", g, e); end
    for (int i = 0; i < 20; i++) begin
      cnt_i = 5'd3;
      cnt_val_i = (i % 2 == 0);
      @(posedge clk_i); #1;
      n_checks++; if (data_o !== g || data_val_o !== 1'b1 || cnt_rdy_o !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d: data %h val %b rdy %b want %h 1 0", i, data_o, data_val_o, cnt_rdy_o, g);
      end
    end
    cnt_val_i = 1'b0;
    data_rdy_i = 1'b1;
    @(posedge clk_i); #1;
    n_checks++; if (data_val_o !== 1'b0 || cnt_rdy_o !== 1'b1) begin n_fail++; $display("FAIL bp_release: val %b rdy %b want 0 1", data_val_o, cnt_rdy_o); end
    n_checks++; if (data_o !== g) begin n_fail++; $display("FAIL bp_after_hold: got %h want %h", data_o, g); end
    @(posedge clk_i); #1;
    n_checks++; if (cnt_rdy_o !== 1'b1 || data_val_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_capture: rdy %b val %b want 1 0", cnt_rdy_o, data_val_o); end
  endtask

  task automatic test_reset_mid();
    logic [4:0]  seq [3] = '{5'd10, 5'd3, 5'd14};
    logic [15:0] run_a [3];
    logic [15:0] e, g; int lat; bit to;
    do_reset();
    cnt_i = 5'd10;
    cnt_val_i = 1'b1;
    @(posedge clk_i); #1;
    cnt_val_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    srst_i = 1'b1;
    @(posedge clk_i); #1;
    srst_i = 1'b0;
    n_checks++; if (cnt_rdy_o !== 1'b1 || data_val_o !== 1'b0 || data_o !== 16'h0000) begin
      n_fail++; $display("FAIL midreset_state: rdy %b val %b data %h want 1 0 0000", cnt_rdy_o, data_val_o, data_o);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i); #1;
      n_checks++; if (data_val_o !== 1'b0) begin n_fail++; $display("FAIL midreset_no_word cyc=%0d: got %b want 0", i, data_val_o); end
    end
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < 3; i++) begin
        run_req(seq[i], e, lat, g, to);
        n_checks++; if (to || g !== e) begin n_fail++; $display("FAIL repro_model run=%0d req=%0d: got %h want %h", r, i, g, e); end
        if (r == 0) run_a[i] = g;
        else begin
          n_checks++; if (g !== run_a[i]) begin n_fail++; $display("FAIL repro_match req=%0d: got %h want %h", i, g, run_a[i]); end
        end
        @(posedge clk_i); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_five();
    test_full();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
